// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write-port arbiter with MDU result FIFO and hazard scoreboard
module rf_write_arbiter #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             wb_hold,
    input  logic             mdu_valid,
    output logic             mdu_ready,
    input  logic [4:0]       mdu_addr,
    input  logic [WIDTH-1:0] mdu_data,
    input  logic             mdu_issue,
    input  logic [4:0]       mdu_issue_addr,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    output logic             id_stall,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [WIDTH-1:0] rf_wdata
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_MDU
    } grant_e;

    // FIFO storage is not reset: entries are only read after being written
    logic [4:0]       fifo_addr_q [DEPTH];
    logic [WIDTH-1:0] fifo_data_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;

    grant_e           grant;
    logic             fifo_empty;
    logic             forced_drain;
    logic             push;
    logic             pop;
    logic [4:0]       head_addr;
    logic [WIDTH-1:0] head_data;
    logic [4:0]       sel_addr;
    logic [WIDTH-1:0] sel_data;

    assign fifo_empty   = (count_q == '0);
    assign forced_drain = !fifo_empty && (starve_q == STARVE_MAX);
    assign head_addr    = fifo_addr_q[rd_ptr_q];
    assign head_data    = fifo_data_q[rd_ptr_q];

    // Full FIFO refuses a push even if the same cycle pops.
    assign mdu_ready = (count_q != COUNT_FULL);
    assign push      = mdu_valid && mdu_ready;

    always_comb begin
        grant   = GNT_NONE;
        wb_hold = 1'b0;
        if (forced_drain) begin
            grant   = GNT_MDU;
            wb_hold = 1'b1;
        end else if (wb_valid) begin
            grant = GNT_WB;
        end else if (!fifo_empty) begin
            grant = GNT_MDU;
        end
    end

    assign pop = (grant == GNT_MDU);

    always_comb begin
        sel_addr = wb_addr;
        sel_data = wb_data;
        if (grant == GNT_MDU) begin
            sel_addr = head_addr;
            sel_data = head_data;
        end
    end

    // r0 is hardwired zero; a popped r0 result still drains the FIFO.
    assign rf_we    = rst && (grant != GNT_NONE) && (sel_addr != 5'd0);
    assign rf_waddr = sel_addr;
    assign rf_wdata = sel_data;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if (pop && (head_addr != 5'd0)) begin
            pending_d[head_addr] = 1'b0;
        end
        if (mdu_issue && (mdu_issue_addr != 5'd0)) begin
            pending_d[mdu_issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    assign id_stall = ((id_rs != 5'd0) && pending_q[id_rs])
                    | ((id_rt != 5'd0) && pending_q[id_rt])
                    | ((id_rd != 5'd0) && pending_q[id_rd]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            pending_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_addr_q[wr_ptr_q] <= mdu_addr;
            fifo_data_q[wr_ptr_q] <= mdu_data;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter against a queue-based reference model
module tb_rf_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_hold;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_addr;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    rf_write_arbiter #(.WIDTH(32), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_hold(wb_hold),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_stall(id_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        hold;
        logic        stall;
        logic        ready;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: FIFO as queues, pending as a bit set, starvation as an integer
    logic [4:0]  m_qa[$];
    logic [31:0] m_qd[$];
    int          m_starve;
    logic [31:0] m_pend;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("rf_we", 32'(rf_we), 32'(mon_e.we));
            if (mon_e.we) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(mon_e.waddr));
                chk("rf_wdata", rf_wdata, mon_e.wdata);
            end
            chk("wb_hold", 32'(wb_hold), 32'(mon_e.hold));
            chk("id_stall", 32'(id_stall), 32'(mon_e.stall));
            chk("mdu_ready", 32'(mdu_ready), 32'(mon_e.ready));
        end
    end

    // Predict this cycle's outputs, advance the model, then let the clock edge commit.
    task automatic commit();
        exp_t        e;
        int          n;
        logic        forced, g_mdu, g_wb, push;
        logic [4:0]  a;
        logic [31:0] d;
        n      = m_qa.size();
        e.ready = (n < DEPTH);
        push   = mdu_valid && e.ready;
        forced = (n > 0) && (m_starve == LIMIT);
        g_mdu  = forced || (!wb_valid && n > 0);
        g_wb   = !forced && wb_valid;
        a = wb_addr;
        d = wb_data;
        if (g_mdu) begin
            a = m_qa[0];
            d = m_qd[0];
        end
        e.hold  = forced;
        e.we    = rst && (g_mdu || g_wb) && (a != 5'd0);
        e.waddr = a;
        e.wdata = d;
        e.stall = ((id_rs != 0) && m_pend[id_rs]) || ((id_rt != 0) && m_pend[id_rt])
               || ((id_rd != 0) && m_pend[id_rd]);
        exp_q.push_back(e);
        if (!rst) begin
            m_qa.delete();
            m_qd.delete();
            m_starve = 0;
            m_pend   = '0;
        end else begin
            if (n == 0 || g_mdu) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            if (g_mdu) begin
                if (a != 0) m_pend[a] = 1'b0;
                void'(m_qa.pop_front());
                void'(m_qd.pop_front());
            end
            if (mdu_issue && mdu_issue_addr != 0) m_pend[mdu_issue_addr] = 1'b1;
            if (push) begin
                m_qa.push_back(mdu_addr);
                m_qd.push_back(mdu_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b1;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
        mdu_issue = 1'b0; mdu_issue_addr = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
    endtask

    task automatic push_mdu(input logic [4:0] a, input logic [31:0] d);
        mdu_valid = 1'b1; mdu_addr = a; mdu_data = d;
    endtask

    initial begin
        m_starve = 0;
        m_pend   = '0;
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with a WB request pending, then released
        rst = 1'b0; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h1111;
        push_mdu(5'd9, 32'h5);
        commit(); commit();
        mdu_valid = 1'b0; rst = 1'b1;
        commit();

        // WB priority over a buffered MDU result
        idle();
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h1111;
        push_mdu(5'd5, 32'hAAAA);
        commit();
        mdu_valid = 1'b0;
        commit();
        wb_valid = 1'b0;
        commit(); commit();

        // Starvation: continuous WB, one MDU entry
        idle();
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444;
        push_mdu(5'd6, 32'h6666);
        commit();
        mdu_valid = 1'b0;
        repeat (8) commit();

        // Full FIFO back-pressure
        idle();
        wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h2222;
        for (int i = 0; i < 4; i++) begin
            push_mdu(5'(10 + i), 32'hB000 + 32'(i));
            commit();
        end
        idle();
        repeat (4) commit();

        // Scoreboard: issue r7, result drains, reissue coinciding with the pop
        idle();
        mdu_issue = 1'b1; mdu_issue_addr = 5'd7; id_rs = 5'd7;
        commit();
        mdu_issue = 1'b0;
        commit();
        id_rs = 5'd0; id_rt = 5'd7;
        commit();
        push_mdu(5'd7, 32'h7777);
        commit();
        mdu_valid = 1'b0;
        commit(); commit();
        mdu_issue = 1'b1; mdu_issue_addr = 5'd7;
        commit();
        mdu_issue = 1'b0;
        push_mdu(5'd7, 32'h7778);
        commit();
        mdu_valid = 1'b0; mdu_issue = 1'b1; mdu_issue_addr = 5'd7;
        commit();
        mdu_issue = 1'b0;
        commit(); commit();

        // Address 0 result drains without a write
        idle();
        push_mdu(5'd0, 32'hDEAD);
        commit();
        idle();
        mdu_issue = 1'b1; mdu_issue_addr = 5'd0; id_rs = 5'd0;
        commit(); commit();

        // Randomized traffic over a narrow register range to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 199) != 0);
            wb_valid       = ($urandom_range(0, 9) < 6);
            wb_addr        = 5'($urandom_range(0, 7));
            wb_data        = $urandom;
            mdu_valid      = ($urandom_range(0, 9) < 4);
            mdu_addr       = 5'($urandom_range(0, 7));
            mdu_data       = $urandom;
            mdu_issue      = ($urandom_range(0, 9) < 3);
            mdu_issue_addr = 5'($urandom_range(0, 7));
            id_rs          = 5'($urandom_range(0, 7));
            id_rt          = 5'($urandom_range(0, 7));
            id_rd          = 5'($urandom_range(0, 31));
            commit();
        end

        idle();
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) chk("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
